// File: rtl/main_memory_model_if.sv
// Request/response bus between the cache controller (master) and the
// backing-store model (slave).
interface main_memory_model_if #(
  parameter int AW = 10
);
  logic          rd_en;
  logic          wr_en;
  logic [AW-1:0] WA;
  logic [31:0]   wdata;
  logic          ready;
  logic [127:0]  rdata_blk;
  logic          busy;

  modport master (
    output rd_en, wr_en, WA, wdata,
    input  ready, rdata_blk, busy
  );

  modport slave (
    input  rd_en, wr_en, WA, wdata,
    output ready, rdata_blk, busy
  );
endinterface

// File: rtl/main_memory_model.sv
// Fixed-latency backing store: 4-word block reads, single-word writes.
// Optional MEM_FAST_WRITE_EN: writes skip the latency counter and complete in one cycle.
module main_memory_model #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024
) (
  input  logic               clk,
  input  logic               RST,
  main_memory_model_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
`ifdef MEM_FAST_WRITE_EN
  localparam bit FAST_WR = 1'b1;
`else
  localparam bit FAST_WR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [31:0] mem [DEPTH] = '{default: '0};

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            op_wr_q, op_wr_d;
  logic [127:0]    rdata_blk_q, rdata_blk_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic [AW-3:0]   blk;

  assign blk = addr_q[AW-1:2];

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    rdata_blk_d = rdata_blk_q;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr_q;
    mem_wdata   = wdata_q;

    // Re-arm only once the controller has released its held request.
    if (!bus.rd_en && !bus.wr_en) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (armed_q && (bus.rd_en || bus.wr_en)) begin
          armed_d = 1'b0;
          addr_d  = bus.WA;
          wdata_d = bus.wdata;
          op_wr_d = bus.wr_en;
          cnt_d   = CNT_LOAD;
          if (FAST_WR && bus.wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = bus.WA;
            mem_wdata = bus.wdata;
            state_d   = DONE;
            ready_d   = 1'b1;
          end else begin
            state_d = BUSY;
            busy_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (op_wr_q) mem_we = 1'b1;
          else rdata_blk_d = {mem[{blk, 2'd3}], mem[{blk, 2'd2}],
                              mem[{blk, 2'd1}], mem[{blk, 2'd0}]};
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_wr_q     <= 1'b0;
      rdata_blk_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      rdata_blk_q <= rdata_blk_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Memory is not cleared by reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !RST) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rdata_blk = rdata_blk_q;
endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model: reset, table-driven read/write vectors, mid-op reset.
module tb_main_memory_model;
  localparam int L = 4;
`ifdef MEM_FAST_WRITE_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   ntests = 0;
  int   nfail  = 0;

  main_memory_model_if #(.AW(10)) bus ();

  main_memory_model #(.LATENCY(L), .DEPTH(1024)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [9:0]   addr;
    logic [31:0]  wdata;
    int           hold;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request, holds it 'hold' cycles past ready, then drains.
  task automatic run_req(input bit wr, input bit rd, input logic [9:0] a, input logic [31:0] d,
                         input int hold, output int lat, output int npulses, output int nbusy);
    bus.wr_en = wr; bus.rd_en = rd; bus.WA = a; bus.wdata = d;
    lat = -1; npulses = 0; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.busy) nbusy++;
      if (bus.ready) begin
        if (lat < 0) lat = c;
        npulses++;
      end
      if (lat >= 0 && c >= lat + hold) break;
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.busy) nbusy++;
      if (bus.ready) npulses++;
    end
  endtask

  initial begin
    int lat, np, nb, exp_lat, c;
    vecs[0] = '{1, 0, 10'h00D, 32'hDEADBEEF, 3, 128'h0};
    vecs[1] = '{0, 1, 10'h00C, 32'h0, 0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    vecs[2] = '{1, 0, 10'h3F8, 32'h11, 0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    vecs[3] = '{1, 0, 10'h3F9, 32'h22, 1, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    vecs[4] = '{1, 0, 10'h3FA, 32'h33, 0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    vecs[5] = '{1, 0, 10'h3FB, 32'h44, 2, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}};
    vecs[6] = '{0, 1, 10'h3FA, 32'h0, 2, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[7] = '{1, 1, 10'h005, 32'h55, 1, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[8] = '{0, 1, 10'h004, 32'h0, 0, {32'h0, 32'h0, 32'h55, 32'h0}};

    rst = 1'b1;
    bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.WA = 10'h000; bus.wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", 128'(bus.ready), 128'h0);
      check("rst_busy", 128'(bus.busy), 128'h0);
      check("rst_rdata", bus.rdata_blk, 128'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_accept_busy", 128'(bus.busy), 128'h1);
    lat = -1;
    for (c = 1; c <= 20; c++) begin
      if (bus.ready) begin lat = c; break; end
      @(posedge clk); #1;
    end
    check("rst_release_read_lat", 128'(lat), 128'(L + 1));
    check("rst_release_read_data", bus.rdata_blk, 128'h0);
    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].hold, lat, np, nb);
      exp_lat = (vecs[i].wr && FAST) ? 1 : L + 1;
      check($sformatf("v%0d_latency", i), 128'(lat), 128'(exp_lat));
      check($sformatf("v%0d_ready_pulses", i), 128'(np), 128'h1);
      check($sformatf("v%0d_busy_cycles", i), 128'(nb), 128'((vecs[i].wr && FAST) ? 0 : L));
      check($sformatf("v%0d_rdata_blk", i), bus.rdata_blk, vecs[i].exp_blk);
    end

    // Reset two cycles after a write is accepted.
    bus.wr_en = 1'b1; bus.WA = 10'h007; bus.wdata = 32'h0000AAAA;
    np = 0;
    @(posedge clk); #1;
    if (bus.ready) np++;
    check("midrst_busy", 128'(bus.busy), 128'(FAST ? 0 : 1));
    @(posedge clk); #1;
    if (bus.ready) np++;
    rst = 1'b1;
    @(posedge clk); #1;
    if (bus.ready) np++;
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    if (bus.ready) np++;
    rst = 1'b0;
    check("midrst_rdata_cleared", bus.rdata_blk, 128'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ready) np++;
    end
    check("midrst_ready_pulses", 128'(np), 128'(FAST ? 1 : 0));
    run_req(1'b0, 1'b1, 10'h004, 32'h0, 0, lat, np, nb);
    check("midrst_read_lat", 128'(lat), 128'(L + 1));
    check("midrst_read_blk", bus.rdata_blk,
          {(FAST ? 32'h0000AAAA : 32'h0), 32'h0, 32'h55, 32'h0});

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/main_memory_model.md
# main_memory_model

Multi-cycle backing-store model that sits directly downstream of the cache controller in the RISC-V-with-cache subsystem. It accepts the controller's level-held `rd_en` / `wr_en` requests, waits a fixed latency, and returns a one-cycle `ready` pulse that drives the controller's `ready_in`. Reads return the whole 4-word cache block containing the requested word. Writes commit a single 32-bit word (write-through).

## Interface
- `LATENCY`, default 4: cycles from request acceptance to the `ready` pulse; legal range 1..15.
- `DEPTH`, default 1024: number of 32-bit words; word address width is 10.
- `clk`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `rd_en`  in  1  block-read request from the cache controller, level-held until `ready` is observed.
- `wr_en`  in  1  word-write request from the cache controller, level-held until `ready` is observed.
- `WA`  in  10  word address; bits [1:0] select the word within the block, bits [9:2] select the block.
- `wdata`  in  32  write data.
- `ready`  out  1  completion pulse, one cycle wide; connects to the cache controller `ready_in`.
- `rdata_blk`  out  128  read block; word k occupies bits [32k+31:32k], with k = offset.
- `busy`  out  1  high while a request is in flight (state `BUSY`).

## Operation
- The FSM has three states: `IDLE`, `BUSY`, `DONE`.
- An `armed` flag gates request acceptance. It is set whenever `rd_en` and `wr_en` are both 0, and cleared on acceptance.
  - Purpose: the controller samples `ready` through a register, so it keeps its request asserted for more than one cycle after completion. Without the flag, that held request would be re-accepted as a new one.
- Acceptance occurs in `IDLE` when `armed` = 1 and (`rd_en` | `wr_en`).
  - On acceptance, latch `WA` and `wdata`, latch the op (`wr_en` takes priority if both are high), load the counter with `LATENCY-1`, and go to `BUSY`.
- In `BUSY`, the counter decrements each cycle. When the counter is 0, perform the op and go to `DONE`.
  - Read: `rdata_blk` ← mem[{WA[9:2],k}] for k = 0..3.
  - Write: mem[WA] ← `wdata`.
- In `DONE`, `ready` = 1 for exactly this cycle, then go to `IDLE`.
- `rdata_blk` holds its value until the next read completes; writes do not alter it.
- Requests dropped while in `BUSY` do not abort the operation; it completes normally.
- The counter width is 4 bits. With `LATENCY` = 1 the counter loads 0, so `BUSY` lasts one cycle.
- Memory contents are zero-initialised at time 0 (model only); `RST` does not clear memory.

## Timing
- Reset values: `ready` = 0, `busy` = 0, `rdata_blk` = 0, state = `IDLE`, `armed` = 1, counter = 0.
- Let cycle A be the edge on which a request is accepted.
  - `busy` is high from A+1 through A+LATENCY.
  - The memory update (write) or `rdata_blk` update (read) is visible from A+LATENCY+1.
  - `ready` is high during cycle A+LATENCY+1 only.
- Total request-to-`ready` latency is LATENCY+1 cycles.
- A new request is accepted no earlier than 2 cycles after `ready`, and only after `rd_en` and `wr_en` have both been observed low.
- Reset mid-operation:
  - An aborted write is not committed.
  - An aborted read leaves `rdata_blk` at 0.
  - No `ready` pulse is emitted.
  - A request held high through and after reset is accepted on the first cycle after `RST` falls (`armed` = 1 out of reset).

## Configuration
- `MEM_FAST_WRITE_EN` defined: writes bypass the latency counter.
  - The write goes `IDLE`→`DONE` directly, committing on the A+1 edge; `ready` is high in A+1.
  - Reads keep full LATENCY+1 timing.
- Not defined: reads and writes share the LATENCY+1 timing described above.

## Test plan
- Reset: assert `RST` for 3 cycles with `rd_en` = 1 → `ready`, `busy` and `rdata_blk` are all 0 throughout; the read is accepted on the first cycle after release.
- Write then read (LATENCY = 4): write `WA` = 0x0D, `wdata` = 0xDEADBEEF, holding `wr_en` 3 cycles past `ready` → `ready` appears exactly 5 cycles after acceptance, and only one write is performed. Then read `WA` = 0x0C → `rdata_blk`[63:32] = 0xDEADBEEF, other words 0, `ready` after 5 cycles.
- Block fill: write 0x11, 0x22, 0x33, 0x44 to words 0x3F8..0x3FB; read `WA` = 0x3FA → `rdata_blk` = {0x44,0x33,0x22,0x11}.
- Simultaneous `rd_en` = `wr_en` = 1 at `WA` = 5, `wdata` = 0x55 → a write is performed; a later read of block 1 shows word 1 = 0x55.
- Reset mid-write: `RST` asserted 2 cycles after accepting a write of 0xAAAA to `WA` = 7 → no `ready` pulse; a subsequent read of block 1 shows word 3 = 0.
- With `MEM_FAST_WRITE_EN`: write `WA` = 2 → `ready` one cycle after acceptance; a read still takes 5 cycles.
